i2c_temp_responder: RTL and testbench

I2C target (responder) that emulates the board temperature sensor at the far end of the two-wire bus driven by the design's I2C master. It oversamples SCL/SDA with the 100 MHz system clock, recognises its 7-bit address, and returns a 16-bit temperature word, MSB first, on read transfers. It accepts single-byte pointer writes. It serves as a bus-level stand-in for the sensor in loopback builds and simulation, and its outputs feed the same temp_data consumers.

---
 rtl/i2c_temp_responder_pkg.sv | 8 +
 rtl/i2c_temp_responder_bus_sync.sv | 41 ++++
 rtl/i2c_temp_responder.sv | 116 +++++++++++
 tb/tb_i2c_temp_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_temp_responder_pkg.sv
// i2c_temp_responder_pkg: shared state encoding and constants for the I2C temperature responder
package i2c_temp_responder_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
  } state_e;
  localparam logic [6:0] DEFAULT_ADDR = 7'h4B;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/i2c_temp_responder_bus_sync.sv
// i2c_bus_sync: synchronises SCL/SDA and produces registered edge and START/STOP strobes
module i2c_bus_sync
  import i2c_temp_responder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_h, sda_h, scl_n, sda_n;
  assign scl_n = scl_q[SYNC_STAGES-1];
  assign sda_n = sda_q[SYNC_STAGES-1];
  assign sda_s = sda_h;
  // Flops reset high so an idle bus produces no spurious edge after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_q     <= '1;
      sda_q     <= '1;
      scl_h     <= 1'b1;
      sda_h     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_q     <= {scl_q[SYNC_STAGES-2:0], scl_in};
      sda_q     <= {sda_q[SYNC_STAGES-2:0], sda_in};
      scl_h     <= scl_n;
      sda_h     <= sda_n;
      scl_rise  <= scl_n & ~scl_h;
      scl_fall  <= ~scl_n & scl_h;
      start_det <= scl_n & scl_h & sda_h & ~sda_n;
      stop_det  <= scl_n & scl_h & ~sda_h & sda_n;
    end
endmodule

// File: rtl/i2c_temp_responder.sv
// i2c_temp_responder: I2C target returning a 16-bit temperature word and accepting pointer writes
module i2c_temp_responder
  import i2c_temp_responder_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter int         HOLD_CYCLES = 30
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  input  logic [15:0] temp_data,
  output logic        sda_oe,
  output logic        busy,
  output logic [7:0]  ptr_reg,
  output logic        rd_done
);
  localparam int HW = $clog2(HOLD_CYCLES);
  state_e        state;
  logic [3:0]    cnt;
  logic [6:0]    sr;
  logic          rw, half, pend, oe_want;
  logic [15:0]   tx;
  logic [HW-1:0] hcnt;
  logic [7:0]    byte_in, cur_byte;
  logic          sda_s, scl_rise, scl_fall, start_det, stop_det;
  i2c_bus_sync u_sync (
    .clk       (clk_100MHz),
    .rst_n     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );
  always_comb begin
    byte_in  = {sr, sda_s};
    cur_byte = half ? tx[7:0] : tx[15:8];
    oe_want  = (state == S_ADDR_ACK) || (state == S_WR_ACK) ||
               (state == S_RD_BYTE && !cur_byte[~cnt[2:0]]);
  end
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sr      <= '0;
      rw      <= 1'b0;
      half    <= 1'b0;
      tx      <= '0;
      busy    <= 1'b0;
      ptr_reg <= '0;
      rd_done <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      if (start_det) begin
        state <= S_ADDR;
        cnt   <= '0;
      end else if (stop_det) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (scl_rise) begin
        cnt <= cnt + 4'd1;
        sr  <= byte_in[6:0];
        case (state)
          S_ADDR: if (cnt == 4'd7) begin
            state <= (byte_in[7:1] == ADDR) ? S_ADDR_ACK : S_IDLE;
            busy  <= byte_in[7:1] == ADDR;
            rw    <= byte_in[0];
          end
          // The word is captured once per read so its two bytes never tear
          S_ADDR_ACK: begin
            cnt   <= '0;
            half  <= 1'b0;
            tx    <= rw ? temp_data : tx;
            state <= rw ? S_RD_BYTE : S_WR_BYTE;
          end
          S_WR_BYTE: if (cnt == 4'd7) begin
            state   <= S_WR_ACK;
            ptr_reg <= byte_in;
          end
          S_WR_ACK: begin
            state <= S_WR_BYTE;
            cnt   <= '0;
          end
          S_RD_BYTE: if (cnt == 4'd7) state <= S_RD_ACK;
          S_RD_ACK: begin
            cnt     <= '0;
            state   <= sda_s ? S_IDLE : S_RD_BYTE;
            busy    <= ~sda_s;
            rd_done <= sda_s;
            half    <= sda_s ? half : ~half;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  // sda_oe only moves a fixed hold time after SCL falls; bus conditions cancel it
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      pend   <= 1'b0;
      hcnt   <= '0;
      sda_oe <= 1'b0;
    end else if (start_det || stop_det) begin
      pend   <= 1'b0;
      sda_oe <= 1'b0;
    end else if (scl_fall) begin
      pend <= 1'b1;
      hcnt <= HW'(HOLD_CYCLES - 2);
    end else if (pend) begin
      pend   <= hcnt != '0;
      hcnt   <= (hcnt != '0) ? hcnt - HW'(1) : hcnt;
      sda_oe <= (hcnt == '0) ? oe_want : sda_oe;
    end
endmodule

// File: tb/tb_i2c_temp_responder.sv
// tb_i2c_temp_responder: bit-level I2C master with table, hand-written and random transfers
module tb_i2c_temp_responder;
  localparam logic [6:0] A = 7'h4B;
  logic clk = 1'b0, rst_n = 1'b0, scl = 1'b1, m_sda = 1'b1;
  logic [15:0] temp = 16'h0C80;
  logic sda_oe, busy, rd_done, sda_bus;
  logic [7:0] ptr_reg;
  assign sda_bus = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_temp_responder dut (
    .clk_100MHz (clk),
    .reset      (rst_n),
    .scl_in     (scl),
    .sda_in     (sda_bus),
    .temp_data  (temp),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .ptr_reg    (ptr_reg),
    .rd_done    (rd_done)
  );

  int checks = 0, failures = 0, cyc = 0, fall_cyc = 0, rd_cnt = 0, r0;
  logic hold_en = 1'b1, prev_oe = 1'b0, an, s;
  logic [7:0] b, mptr, addr, d;
  logic [15:0] word, snap;

  typedef struct {
    logic [7:0]       addr;
    int               nrd;
    logic [15:0]      t0, t1;
    logic             ack;
    logic [2:0][7:0]  eb;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rd_done) rd_cnt++;
    if (sda_oe !== prev_oe) begin
      if (hold_en) begin
        chk("hold_delay", cyc - fall_cyc, 33);
        chk("hold_scl_low", {31'd0, scl}, 0);
      end
      prev_oe = sda_oe;
    end
  end

  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic bit_cycle(input logic bv, output logic sv);
    w(40); m_sda = bv;
    w(10); scl = 1'b1;
    w(25); sv = sda_bus;
    w(25); scl = 1'b0; fall_cyc = cyc;
  endtask
  task automatic start_c();
    m_sda = 1'b0;
    w(25); scl = 1'b0; fall_cyc = cyc;
  endtask
  task automatic rstart_c();
    w(40); m_sda = 1'b1;
    w(10); scl = 1'b1;
    w(25); m_sda = 1'b0;
    w(25); scl = 1'b0; fall_cyc = cyc;
  endtask
  task automatic stop_c();
    w(40); m_sda = 1'b0;
    w(10); scl = 1'b1;
    w(25); m_sda = 1'b1;
    w(25);
  endtask
  task automatic send_byte(input logic [7:0] v, output logic ack_n);
    logic x;
    for (int i = 7; i >= 0; i--) bit_cycle(v[i], x);
    bit_cycle(1'b1, ack_n);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic x;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, x);
      v = {v[6:0], x};
    end
    bit_cycle(nack, x);
  endtask

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vt[0] = '{8'h97, 2, 16'h0C80, 16'h0C80, 1'b1, {8'h00, 8'h80, 8'h0C}};
    vt[1] = '{8'h97, 2, 16'h0C80, 16'h1234, 1'b1, {8'h00, 8'h80, 8'h0C}};
    vt[2] = '{8'h97, 3, 16'hA5F0, 16'h0000, 1'b1, {8'hA5, 8'hF0, 8'hA5}};
    vt[3] = '{8'h91, 0, 16'h0C80, 16'h0C80, 1'b0, {8'h00, 8'h00, 8'h00}};
    vt[4] = '{8'h96, 0, 16'h0C80, 16'h0C80, 1'b1, {8'h00, 8'h00, 8'h00}};
    w(5);
    chk("rst_sda_oe", {31'd0, sda_oe}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ptr", {24'd0, ptr_reg}, 0);
    chk("rst_rd_done", {31'd0, rd_done}, 0);
    rst_n = 1'b1;
    w(20);

    for (int i = 0; i < 5; i++) begin
      temp = vt[i].t0;
      start_c();
      send_byte(vt[i].addr, an);
      chk("tbl_addr_ack", {31'd0, ~an}, {31'd0, vt[i].ack});
      chk("tbl_busy", {31'd0, busy}, {31'd0, vt[i].ack});
      if (!vt[i].ack) begin
        for (int k = 0; k < 16; k++) begin
          bit_cycle(1'b1, s);
          word = {word[14:0], s};
        end
        chk("mismatch_sda", {16'd0, word}, 32'hFFFF);
        chk("mismatch_busy", {31'd0, busy}, 0);
      end
      r0 = rd_cnt;
      for (int k = 0; k < vt[i].nrd; k++) begin
        recv_byte(k == vt[i].nrd - 1, b);
        chk("tbl_rd_byte", {24'd0, b}, {24'd0, vt[i].eb[k]});
        temp = vt[i].t1;
      end
      if (vt[i].nrd > 0) chk("tbl_rd_done", rd_cnt - r0, 1);
      stop_c();
      w(5);
      chk("tbl_busy_stop", {31'd0, busy}, 0);
    end

    temp = 16'h0C80;
    start_c();
    send_byte(8'h96, an); chk("wr_addr_ack", {31'd0, an}, 0);
    send_byte(8'h03, an); chk("wr_data_ack", {31'd0, an}, 0);
    chk("wr_ptr", {24'd0, ptr_reg}, 32'h03);
    rstart_c();
    send_byte(8'h97, an); chk("sr_addr_ack", {31'd0, an}, 0);
    recv_byte(1'b0, b); chk("sr_msb", {24'd0, b}, 32'h0C);
    recv_byte(1'b1, b); chk("sr_lsb", {24'd0, b}, 32'h80);
    stop_c();
    w(5);
    chk("sr_busy_stop", {31'd0, busy}, 0);

    start_c();
    send_byte(8'h97, an); chk("mid_addr_ack", {31'd0, an}, 0);
    for (int k = 0; k < 4; k++) begin
      bit_cycle(1'b1, s);
      b = {b[6:0], s};
    end
    chk("mid_nibble", {28'd0, b[3:0]}, 0);
    rstart_c();
    temp = 16'hBEEF;
    send_byte(8'h97, an); chk("mid_readdr_ack", {31'd0, an}, 0);
    recv_byte(1'b0, b); chk("mid_msb", {24'd0, b}, 32'hBE);
    recv_byte(1'b1, b); chk("mid_lsb", {24'd0, b}, 32'hEF);
    stop_c();

    start_c();
    for (int i = 7; i >= 0; i--) begin
      addr = 8'h96;
      bit_cycle(addr[i], s);
    end
    w(40);
    chk("ack_driven", {31'd0, sda_oe}, 1);
    chk("ptr_before_rst", {24'd0, ptr_reg}, 32'h03);
    hold_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_sda_oe", {31'd0, sda_oe}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_ptr", {24'd0, ptr_reg}, 0);
    chk("arst_rd_done", {31'd0, rd_done}, 0);
    w(3); rst_n = 1'b1;
    w(3); scl = 1'b1; m_sda = 1'b1;
    w(60); hold_en = 1'b1;

    mptr = 8'h00;
    for (int t = 0; t < 5; t++) begin
      logic match, rwb;
      int n;
      match = $urandom_range(0, 3) != 0;
      rwb = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      if (addr[7:1] == A) addr[1] = ~addr[1];
      if (match) addr = {A, rwb};
      temp = 16'($urandom);
      snap = temp;
      start_c();
      send_byte(addr, an);
      chk("rnd_addr_ack", {31'd0, ~an}, {31'd0, match});
      n = $urandom_range(1, 3);
      if (match && !rwb)
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          send_byte(d, an);
          mptr = d;
          chk("rnd_wr_ack", {31'd0, an}, 0);
          chk("rnd_ptr", {24'd0, ptr_reg}, {24'd0, mptr});
        end
      if (match && rwb) begin
        r0 = rd_cnt;
        for (int k = 0; k < n; k++) begin
          recv_byte(k == n - 1, b);
          chk("rnd_rd_byte", {24'd0, b}, {24'd0, (k % 2 == 0) ? snap[15:8] : snap[7:0]});
          temp = 16'($urandom);
        end
        chk("rnd_rd_done", rd_cnt - r0, 1);
      end
      stop_c();
      w(5);
      chk("rnd_busy_stop", {31'd0, busy}, 0);
      chk("rnd_ptr_hold", {24'd0, ptr_reg}, {24'd0, mptr});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
